// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus sequencers: state encodings, bus polarity,
// default phase timing and the fixed RAM entry order.
package rtc_bus_pkg;

  localparam logic ACT_LO = 1'b0;
  localparam logic INACT_HI = 1'b1;

  localparam int N_REGS = 7;

  localparam int T_SU_DEF  = 2;
  localparam int T_PW_DEF  = 4;
  localparam int T_HD_DEF  = 2;
  localparam int T_GAP_DEF = 2;

  localparam logic [2:0] IDX_CMD  = 3'd0;
  localparam logic [2:0] IDX_SEG  = 3'd1;
  localparam logic [2:0] IDX_MIN  = 3'd2;
  localparam logic [2:0] IDX_HORA = 3'd3;
  localparam logic [2:0] IDX_DIA  = 3'd4;
  localparam logic [2:0] IDX_MES  = 3'd5;
  localparam logic [2:0] IDX_ANIO = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_RD_A = 3'd2,
    ST_RD_D = 3'd3,
    ST_CAP  = 3'd4,
    ST_ADDR = 3'd5,
    ST_DATA = 3'd6
  } seq_state_t;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_SU   = 3'd1,
    PH_PW   = 3'd2,
    PH_HD   = 3'd3,
    PH_GAP  = 3'd4
  } phase_state_t;

  // RAM slot of an entry: sel = 0 is the RTC register address, sel = 1 the data byte.
  function automatic logic [3:0] ram_slot(input logic [2:0] idx, input logic sel);
    return {idx, sel};
  endfunction

endpackage

// File: rtl/rtc_bus_phase.sv
// One setup/pulse/hold cycle on the RTC multiplexed bus, optionally followed by
// a chip-select-high gap. A go pulse always (re)starts a phase on the next cycle.
module rtc_bus_phase
  import rtc_bus_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_PW  = T_PW_DEF,
  parameter int T_HD  = T_HD_DEF,
  parameter int T_GAP = T_GAP_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic a_d_val,
  input  logic with_gap,
  output logic a_d,
  output logic cs_n,
  output logic wr_n,
  output logic oe,
  output logic phase_done
);

  localparam logic [3:0] LD_SU  = 4'(T_SU - 1);
  localparam logic [3:0] LD_PW  = 4'(T_PW - 1);
  localparam logic [3:0] LD_HD  = 4'(T_HD - 1);
  localparam logic [3:0] LD_GAP = 4'(T_GAP - 1);

  phase_state_t ph_r, ph_n;
  logic [3:0]   cnt_r, cnt_n;
  logic         gap_r, gap_n;
  logic         on_bus_s;
  logic         a_d_r, cs_n_r, wr_n_r, oe_r, phase_done_r;

  // Next phase step; a fresh go takes priority over the running phase.
  always_comb begin
    ph_n  = ph_r;
    cnt_n = cnt_r;
    gap_n = gap_r;
    if (go) begin
      ph_n  = PH_SU;
      cnt_n = LD_SU;
      gap_n = with_gap;
    end else begin
      case (ph_r)
        PH_SU: begin
          if (cnt_r == 4'd0) begin
            ph_n  = PH_PW;
            cnt_n = LD_PW;
          end else begin
            cnt_n = cnt_r - 4'd1;
          end
        end
        PH_PW: begin
          if (cnt_r == 4'd0) begin
            ph_n  = PH_HD;
            cnt_n = LD_HD;
          end else begin
            cnt_n = cnt_r - 4'd1;
          end
        end
        PH_HD: begin
          if (cnt_r == 4'd0) begin
            if (gap_r) begin
              ph_n  = PH_GAP;
              cnt_n = LD_GAP;
            end else begin
              ph_n  = PH_IDLE;
              cnt_n = 4'd0;
            end
          end else begin
            cnt_n = cnt_r - 4'd1;
          end
        end
        PH_GAP: begin
          if (cnt_r == 4'd0) begin
            ph_n  = PH_IDLE;
            cnt_n = 4'd0;
          end else begin
            cnt_n = cnt_r - 4'd1;
          end
        end
        default: begin
          ph_n  = PH_IDLE;
          cnt_n = 4'd0;
        end
      endcase
    end
    on_bus_s = (ph_n == PH_SU) || (ph_n == PH_PW) || (ph_n == PH_HD);
  end

  // Phase state plus bus strobes registered from the next phase step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_r         <= PH_IDLE;
      cnt_r        <= 4'd0;
      gap_r        <= 1'b0;
      a_d_r        <= 1'b1;
      cs_n_r       <= INACT_HI;
      wr_n_r       <= INACT_HI;
      oe_r         <= 1'b0;
      phase_done_r <= 1'b0;
    end else begin
      ph_r         <= ph_n;
      cnt_r        <= cnt_n;
      gap_r        <= gap_n;
      a_d_r        <= go ? a_d_val : a_d_r;
      cs_n_r       <= on_bus_s ? ACT_LO : INACT_HI;
      wr_n_r       <= (ph_n == PH_PW) ? ACT_LO : INACT_HI;
      oe_r         <= on_bus_s;
      phase_done_r <= (cnt_n == 4'd0) &&
                      (((ph_n == PH_HD) && !gap_n) || (ph_n == PH_GAP));
    end
  end

  assign a_d        = a_d_r;
  assign cs_n       = cs_n_r;
  assign wr_n       = wr_n_r;
  assign oe         = oe_r;
  assign phase_done = phase_done_r;

endmodule

// File: rtl/rtc_write_sequencer.sv
// Copies the enabled RAM entries (address byte, data byte) into the RTC using
// one address phase and one data phase per entry on the multiplexed bus.
module rtc_write_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int T_SU  = T_SU_DEF,
  parameter int T_PW  = T_PW_DEF,
  parameter int T_HD  = T_HD_DEF,
  parameter int T_GAP = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] reg_mask,
  output logic       busy,
  output logic       done,
  output logic [3:0] ram_addr,
  output logic       ram_rd_en,
  input  logic [7:0] ram_rdata,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] bus_dout,
  output logic       bus_oe
);

  seq_state_t state_r, state_n;
  logic [2:0] idx_r, idx_n;
  logic [6:0] mask_r, mask_n;
  logic       last_s;
  logic [7:0] addr_byte_r, data_byte_r;
  logic       busy_r, done_r, ram_rd_en_r;
  logic [3:0] ram_addr_r;
  logic [7:0] bus_dout_r;
  logic       go_s, data_go_s, phase_done_s;

  // Entry walk: masked entries cost a single SEL cycle.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    mask_n  = mask_r;
    last_s  = (idx_r == IDX_ANIO);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SEL;
          idx_n   = IDX_CMD;
          mask_n  = reg_mask;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SEL: begin
        if (mask_r[idx_r]) begin
          state_n = ST_RD_A;
        end else if (last_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_SEL;
          idx_n   = idx_r + 3'd1;
        end
      end
      ST_RD_A: state_n = ST_RD_D;
      ST_RD_D: state_n = ST_CAP;
      ST_CAP:  state_n = ST_ADDR;
      ST_ADDR: begin
        if (phase_done_s) begin
          state_n = ST_DATA;
        end else begin
          state_n = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (phase_done_s) begin
          if (last_s) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_SEL;
            idx_n   = idx_r + 3'd1;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The data phase is launched on the same edge the address phase ends, so cs stays low.
  assign data_go_s = (state_r == ST_ADDR);
  assign go_s      = (state_r == ST_CAP) || (data_go_s && phase_done_s);

  // Sequencer state, RAM fetch latches and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= 3'd0;
      mask_r      <= 7'd0;
      addr_byte_r <= 8'h00;
      data_byte_r <= 8'h00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ram_rd_en_r <= 1'b0;
      ram_addr_r  <= 4'd0;
      bus_dout_r  <= 8'h00;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      mask_r      <= mask_n;
      addr_byte_r <= (state_r == ST_RD_D) ? ram_rdata : addr_byte_r;
      data_byte_r <= (state_r == ST_CAP) ? ram_rdata : data_byte_r;
      busy_r      <= (state_n != ST_IDLE);
      done_r      <= (state_r != ST_IDLE) && (state_n == ST_IDLE);
      ram_rd_en_r <= (state_n == ST_RD_A) || (state_n == ST_RD_D);
      case (state_n)
        ST_RD_A: ram_addr_r <= ram_slot(idx_n, 1'b0);
        ST_RD_D: ram_addr_r <= ram_slot(idx_n, 1'b1);
        default: ram_addr_r <= 4'd0;
      endcase
      case (state_n)
        ST_ADDR: bus_dout_r <= addr_byte_r;
        ST_DATA: bus_dout_r <= data_byte_r;
        default: bus_dout_r <= 8'h00;
      endcase
    end
  end

  rtc_bus_phase #(
    .T_SU  (T_SU),
    .T_PW  (T_PW),
    .T_HD  (T_HD),
    .T_GAP (T_GAP)
  ) u_phase (
    .clk        (clk),
    .reset      (reset),
    .go         (go_s),
    .a_d_val    (data_go_s),
    .with_gap   (data_go_s),
    .a_d        (a_d),
    .cs_n       (cs),
    .wr_n       (wr),
    .oe         (bus_oe),
    .phase_done (phase_done_s)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign ram_rd_en = ram_rd_en_r;
  assign ram_addr  = ram_addr_r;
  assign bus_dout  = bus_dout_r;
  assign rd        = INACT_HI;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Bench for rtc_write_sequencer: a per-cycle timeline model of each run plus
// literal checks on bus byte order, busy length and done position.
module tb_rtc_write_sequencer;

  localparam int SU = 2, PW = 4, HD = 2, GP = 2;
  localparam int A0 = 4;
  localparam int A_END = A0 + SU + PW + HD;
  localparam int D_END = A_END + SU + PW + HD;
  localparam int ENT = D_END + GP;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [6:0] reg_mask = 7'd0;
  logic       busy, done, ram_rd_en, a_d, cs, rd, wr, bus_oe;
  logic [3:0] ram_addr;
  logic [7:0] ram_rdata = 8'h00;
  logic [7:0] bus_dout;

  rtc_write_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .reg_mask(reg_mask),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
    .ram_rdata(ram_rdata), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
    .bus_dout(bus_dout), .bus_oe(bus_oe)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  always @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];

  // ctl = {busy, done, cs, wr, a_d, bus_oe, rd, ram_rd_en}
  typedef struct packed {
    logic [7:0] ctl;
    logic       chk_dout;
    logic [7:0] dout;
    logic       chk_addr;
    logic [3:0] addr;
  } exp_t;

  exp_t expq[$];
  exp_t e_cur;
  exp_t idle_rec;
  logic [7:0] ctl_now;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, t0 = 0;
  int busy_cnt, done_at, cs_low, wr_low;
  logic prev_wr = 1'b1;
  logic [8:0] bytes[$];

  logic [8:0] exp2 [14] = '{9'h0F0, 9'h100, 9'h021, 9'h145, 9'h022, 9'h130, 9'h023,
                            9'h112, 9'h024, 9'h115, 9'h025, 9'h109, 9'h026, 9'h116};
  logic [8:0] exp3 [4]  = '{9'h021, 9'h145, 9'h022, 9'h130};

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h time=%0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected timeline of one run, one record per clock after the accepting edge.
  task automatic push_run(input logic [6:0] m);
    exp_t r;
    logic in_a, in_d, pw, rde;
    for (int i = 0; i < 7; i++) begin
      if (m[i]) begin
        for (int o = 0; o < ENT; o++) begin
          in_a = (o >= A0) && (o < A_END);
          in_d = (o >= A_END) && (o < D_END);
          pw   = ((o >= A0 + SU) && (o < A0 + SU + PW)) ||
                 ((o >= A_END + SU) && (o < A_END + SU + PW));
          rde  = (o == 1) || (o == 2);
          r.ctl      = {1'b1, 1'b0, !(in_a || in_d), !pw, !in_a, in_a || in_d, 1'b1, rde};
          r.chk_dout = in_a || in_d;
          r.dout     = in_a ? mem[2*i] : mem[2*i+1];
          r.chk_addr = rde;
          r.addr     = 4'(2*i + ((o == 2) ? 1 : 0));
          expq.push_back(r);
        end
      end else begin
        r = idle_rec;
        r.ctl[7] = 1'b1;
        expq.push_back(r);
      end
    end
    r = idle_rec;
    r.ctl[6] = 1'b1;
    expq.push_back(r);
  endtask

  task automatic run(input logic [6:0] m);
    if (expq.size() == 0) expq.push_back(idle_rec);
    push_run(m);
    t0 = cyc;
    start = 1'b1;
    reg_mask = m;
    tick();
    start = 1'b0;
    reg_mask = ~m;
  endtask

  task automatic clear_meas();
    busy_cnt = 0;
    done_at = -1;
    cs_low = 0;
    wr_low = 0;
    bytes.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison against the model, and measurement counters.
  always @(negedge clk) begin
    ctl_now = {busy, done, cs, wr, a_d, bus_oe, rd, ram_rd_en};
    if (!reset) begin
      cmp("reset_ctl", ctl_now, 8'h3A);
      cmp("reset_dout", bus_dout, 8'h00);
      cmp("reset_addr", ram_addr, 4'h0);
    end else begin
      if (expq.size() > 0) e_cur = expq.pop_front();
      else e_cur = idle_rec;
      cmp("ctl", ctl_now, e_cur.ctl);
      if (e_cur.chk_dout) cmp("bus_dout", bus_dout, e_cur.dout);
      if (e_cur.chk_addr) cmp("ram_addr", ram_addr, e_cur.addr);
      if (busy) busy_cnt++;
      if (done) done_at = cyc - t0;
      if (!cs) cs_low++;
      if (!wr) wr_low++;
      if (!wr && prev_wr) bytes.push_back({a_d, bus_dout});
    end
    prev_wr = wr;
  end

  initial begin
    idle_rec = '{ctl: 8'h3A, chk_dout: 1'b0, dout: 8'h00, chk_addr: 1'b0, addr: 4'h0};
    mem = '{8'hF0, 8'h00, 8'h21, 8'h45, 8'h22, 8'h30, 8'h23, 8'h12,
            8'h24, 8'h15, 8'h25, 8'h09, 8'h26, 8'h16, 8'h00, 8'h00};
    clear_meas();

    // 1: reset, then idle with no start
    repeat (3) tick();
    reset = 1'b1;
    repeat (50) tick();
    cmp("idle_dout", bus_dout, 8'h00);
    cmp("idle_addr", ram_addr, 4'h0);
    cmp("idle_rd", rd, 1'b1);

    // 2: all entries
    clear_meas();
    run(7'h7F);
    repeat (160) tick();
    cmp("full_busy_cycles", busy_cnt, 154);
    cmp("full_done_at", done_at, 155);
    cmp("full_wr_low_cycles", wr_low, 56);
    cmp("full_nbytes", bytes.size(), 14);
    if (bytes.size() == 14)
      for (int k = 0; k < 14; k++) cmp("full_byte", bytes[k], exp2[k]);

    // 3: entries 1 and 2 only
    clear_meas();
    run(7'h06);
    repeat (55) tick();
    cmp("m06_busy_cycles", busy_cnt, 49);
    cmp("m06_done_at", done_at, 50);
    cmp("m06_nbytes", bytes.size(), 4);
    if (bytes.size() == 4)
      for (int k = 0; k < 4; k++) cmp("m06_byte", bytes[k], exp3[k]);

    // 4: nothing enabled
    clear_meas();
    run(7'h00);
    repeat (12) tick();
    cmp("m00_busy_cycles", busy_cnt, 7);
    cmp("m00_done_at", done_at, 8);
    cmp("m00_cs_low", cs_low, 0);

    // 5: start ignored mid-run, then accepted in the done cycle
    run(7'h7F);
    repeat (18) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (135) tick();
    cmp("b2b_done_now", done, 1'b1);
    run(7'h06);
    cmp("b2b_busy_next", busy, 1'b1);
    repeat (55) tick();

    // 6: reset during the write pulse of the address phase of entry 3
    run(7'h7F);
    repeat (73) tick();
    cmp("pre_reset_wr_low", wr, 1'b0);
    #2;
    reset = 1'b0;
    expq.delete();
    #1;
    cmp("async_wr", wr, 1'b1);
    cmp("async_cs", cs, 1'b1);
    cmp("async_oe", bus_oe, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    clear_meas();
    run(7'h7F);
    repeat (10) tick();
    cmp("restart_has_byte", (bytes.size() > 0) ? 1 : 0, 1);
    if (bytes.size() > 0) cmp("restart_first_byte", bytes[0], 9'h0F0);
    repeat (150) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
